// File: rtl/mult_hilo.sv
// rtl/mult_hilo.sv - 32x32 signed/unsigned multiplier into HI/LO using an external 16x16 multiplier
module mult_hilo (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_p,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, FIX} state_t;

  state_t      state, state_nxt;
  logic [31:0] ma, mb;
  logic        neg;
  logic [63:0] acc;
  logic [63:0] addend;
  logic [31:0] mag_a, mag_b;

  // Operand magnitudes; 0x80000000 negates to itself and is then read as unsigned 2^31.
  always_comb begin
    mag_a = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
    mag_b = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, multiplier operand selection and the shifted partial product to accumulate.
  always_comb begin
    state_nxt = state;
    mul_a     = 16'd0;
    mul_b     = 16'd0;
    addend    = 64'd0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) state_nxt = P0;
      P0: begin
        mul_a     = ma[15:0];
        mul_b     = mb[15:0];
        addend    = {32'd0, mul_p};
        state_nxt = P1;
      end
      P1: begin
        mul_a     = ma[15:0];
        mul_b     = mb[31:16];
        addend    = {16'd0, mul_p, 16'd0};
        state_nxt = P2;
      end
      P2: begin
        mul_a     = ma[31:16];
        mul_b     = mb[15:0];
        addend    = {16'd0, mul_p, 16'd0};
        state_nxt = P3;
      end
      P3: begin
        mul_a     = ma[31:16];
        mul_b     = mb[31:16];
        addend    = {mul_p, 32'd0};
        state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, partial-product accumulation and the sign-corrected HI/LO write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ma   <= 32'd0;
      mb   <= 32'd0;
      neg  <= 1'b0;
      acc  <= 64'd0;
      hi   <= 32'd0;
      lo   <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ma  <= mag_a;
            mb  <= mag_b;
            neg <= is_signed & (op_a[31] ^ op_b[31]);
            acc <= 64'd0;
          end
        end
        P0, P1, P2, P3: acc <= acc + addend;
        FIX: begin
          {hi, lo} <= neg ? (~acc + 64'd1) : acc;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_hilo.sv
// tb/tb_mult_hilo.sv - randomized self-checking bench for mult_hilo against a 64-bit product model
module tb_mult_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a, op_b;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
  logic        busy, done;
  logic [31:0] hi, lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  mult_hilo dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // External 16x16 multiplier: exact combinational product.
  assign mul_p = {16'd0, mul_a} * {16'd0, mul_b};

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: an accepted request completes five edges later; requests while busy are dropped.
  int          m_remain = 0;
  logic        m_done = 1'b0;
  logic [63:0] m_pend = 64'd0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_remain = 0;
      m_done   = 1'b0;
      m_hi     = 32'd0;
      m_lo     = 32'd0;
    end else begin
      m_done = 1'b0;
      if (m_remain > 0) begin
        m_remain = m_remain - 1;
        if (m_remain == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_pend   = ref_prod(op_a, op_b, is_signed);
        m_remain = 5;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_remain != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    if (m_remain == 0) chk("mul_idle", 64'({mul_a, mul_b}), 64'd0);
  end

  task automatic wait_done();
    int k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  // Starts an operation from the current negedge and returns on the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    int k;
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("latency", 64'(k), 64'd6);
    chk("result", {hi, lo}, ref_prod(a, b, s));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = 32'd0; op_b = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    run_op(32'h0000AAAA, 32'h0000AAAA, 1'b0);
    chk("lit_aaaa", {hi, lo}, 64'h00000000_71C638E4);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("lit_multu_ff", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("lit_mult_ff", {hi, lo}, 64'h00000000_00000001);
    run_op(32'hFFFFFFFD, 32'h00000005, 1'b1);
    chk("lit_m3x5", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op(32'h80000000, 32'h80000000, 1'b1);
    chk("lit_min_sq", {hi, lo}, 64'h40000000_00000000);

    // Start pulsed during P2 must be dropped; start on the done cycle must be taken.
    @(negedge clk);
    op_a = 32'd7; op_b = 32'd6; is_signed = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done();
    chk("lit_7x6", {hi, lo}, 64'd42);
    op_a = 32'd5; op_b = 32'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_done_start", 64'(busy), 64'd1);
    wait_done();
    chk("lit_5x5", {hi, lo}, 64'd25);

    // Reset during P1 discards the operation.
    @(negedge clk);
    op_a = 32'h12345678; op_b = 32'h9ABCDEF0; is_signed = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_hi", 64'(hi), 64'd0);
    chk("async_lo", 64'(lo), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_done", 64'(done), 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (8) @(negedge clk);
    run_op(32'd2, 32'd3, 1'b0);
    chk("lit_2x3", {hi, lo}, 64'd6);

    // Randomized operations with random gaps, including back-to-back on the done cycle.
    for (int i = 0; i < 300; i++) begin
      run_op(pick(), pick(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mult_hilo.md
MULT_HILO -- requirements
Module: mult_hilo

Interface
REQ-001: The block SHALL have no parameters.
REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003: reset  input  1  reset, asynchronous, active-high.
REQ-004: start  input  1  request a multiply; sampled only in IDLE.
REQ-005: is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
REQ-006: op_a  input  32  multiplicand; sampled with start.
REQ-007: op_b  input  32  multiplier; sampled with start.
REQ-008: mul_a  output  16  operand A to the external 16x16 unsigned combinational multiplier.
REQ-009: mul_b  output  16  operand B to the external multiplier.
REQ-010: mul_p  input  32  unsigned product mul_a*mul_b returned in the same cycle.
REQ-011: busy  output  1  high while an operation is in progress.
REQ-012: done  output  1  one-cycle pulse; hi/lo hold the new result.
REQ-013: hi  output  32  upper 32 bits of the 64-bit product (HI register).
REQ-014: lo  output  32  lower 32 bits of the 64-bit product (LO register).

Function
REQ-015: The FSM SHALL have the states IDLE, P0, P1, P2, P3 and FIX.
REQ-016: In IDLE with start=1, the block SHALL latch the operand magnitudes ma/mb on the next edge (|op| when is_signed=1 and the MSB is 1, else op unchanged), then set neg = is_signed & (op_a[31]^op_b[31]), clear the 64-bit accumulator acc, and go to P0.
REQ-017: A magnitude of 0x80000000 SHALL be handled as unsigned 2^31 without overflow.
REQ-018: In P0 the block SHALL drive mul_a=ma[15:0] and mul_b=mb[15:0], add mul_p to acc, and go to P1.
REQ-019: In P1 the block SHALL drive ma[15:0]/mb[31:16], add mul_p<<16 to acc, and go to P2.
REQ-020: In P2 the block SHALL drive ma[31:16]/mb[15:0], add mul_p<<16 to acc, and go to P3.
REQ-021: In P3 the block SHALL drive ma[31:16]/mb[31:16] and add mul_p<<32 to acc.
REQ-022: All accumulator additions SHALL be 64-bit modulo 2^64.
REQ-023: In FIX, {hi,lo} SHALL load acc, or (~acc+1) when neg=1, at the next edge; that same edge SHALL set done=1 for one cycle and return the FSM to IDLE.
REQ-024: mul_a and mul_b SHALL be 0 in IDLE and FIX.
REQ-025: busy SHALL be 1 exactly in states P0..FIX and 0 in IDLE.
REQ-026: Latency: with start sampled at edge E, done SHALL be high in the cycle after edge E+5; busy SHALL be high for 5 cycles.
REQ-027: start while busy=1 SHALL be ignored, with no effect on operands or the FSM.
REQ-028: start in the cycle where done=1 SHALL be accepted, because the FSM is already in IDLE.
REQ-029: hi/lo SHALL change only at the FIX edge and SHALL hold their values between operations and while busy.
REQ-030: done SHALL never be high for two consecutive cycles unless a new operation completes.

Reset
REQ-031: Asserting reset at any time, including mid-operation, SHALL immediately force FSM=IDLE, hi=0, lo=0, busy=0, done=0, mul_a=0, mul_b=0, acc=0 and neg=0.
REQ-032: An operation interrupted by reset SHALL be discarded, and no done pulse SHALL follow it.
REQ-033: After reset deasserts, the first start SHALL be accepted on the next edge.

Verification
REQ-034: MULTU 0x0000AAAA*0x0000AAAA -> hi=0x00000000, lo=0x71C638E4, done exactly 5 cycles after the start edge.
REQ-035: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT of the same operands (-1*-1) -> hi=0x00000000, lo=0x00000001.
REQ-036: MULT 0xFFFFFFFD*0x00000005 (-3*5) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-037: start pulsed during P2 of an operation 7*6 -> ignored; the result stays hi=0, lo=42 with a single done pulse; a start on the done cycle begins a new operation (busy=1 on the next cycle).
REQ-038: reset asserted during P1 -> hi=lo=0, busy=0 immediately and no done pulse; a subsequent MULTU 2*3 -> lo=6 after 5 cycles.
REQ-039: The bench SHALL model mul_p as the exact combinational product of mul_a and mul_b, and SHALL compare every result against a 64-bit reference product.
